// File: rtl/imem_arbiter_if.sv
// Bus bundle for the instruction-memory arbiter.
// Groups the loader request channel, the fetch request/response channel,
// the memory port and the status flags.
//   slave  : the arbiter's view (takes requests, drives the memory port)
//   master : the environment's view (requesters, memory, status observer)
interface imem_arbiter_if;
    // loader write channel
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        boot_done;
    // fetch read channel
    logic        f_valid;
    logic [31:0] f_addr;
    logic        f_ready;
    logic [31:0] f_rdata;
    logic        f_rvalid;
    // memory port (registered read data, one-cycle latency)
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;
    // status
    logic        running;
    logic        err;

    modport slave (
        input  ld_valid, ld_addr, ld_data, boot_done,
        input  f_valid, f_addr, mem_rdata,
        output ld_ready, f_ready, f_rdata, f_rvalid,
        output mem_addr, mem_wdata, mem_rw, running, err
    );

    modport master (
        output ld_valid, ld_addr, ld_data, boot_done,
        output f_valid, f_addr, mem_rdata,
        input  ld_ready, f_ready, f_rdata, f_rvalid,
        input  mem_addr, mem_wdata, mem_rw, running, err
    );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter between a boot loader (writes) and an
// instruction fetch unit (reads) sharing one single-port memory.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : imem_arbiter_if.slave (loader channel, fetch channel,
//           memory port, running/err status)
// BOOT only serves the loader. RUN grants at most one requester per cycle,
// loader first, except that fetch wins after MAX_WAIT consecutive losses.
module imem_arbiter #(
    parameter int ADDR_BITS = 5,
    parameter int MAX_WAIT  = 4
) (
    input  logic          clk,
    input  logic          reset,
    imem_arbiter_if.slave bus
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic              err_reg, err_next;
    logic              rvalid_reg;

    logic ld_grant;
    logic f_grant;
    logic ld_in_range;
    logic ld_issue;

    // Any address bit at or above ADDR_BITS puts the write outside the array.
    assign ld_in_range = ((bus.ld_addr >> ADDR_BITS) == 32'd0);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_BOOT;
            wait_reg   <= '0;
            err_reg    <= 1'b0;
            rvalid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wait_reg   <= wait_next;
            err_reg    <= err_next;
            rvalid_reg <= f_grant;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        err_next   = err_reg | (ld_grant & ~ld_in_range);

        // A pending loader write keeps us in BOOT until it has gone through.
        if (state_reg == ST_BOOT && bus.boot_done && !bus.ld_valid) begin
            state_next = ST_RUN;
        end

        if (state_reg == ST_RUN) begin
            if (f_grant) begin
                wait_next = '0;
            end else if (bus.f_valid && wait_reg != WAIT_MAX) begin
                wait_next = wait_reg + WAIT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Output logic: grants and memory drive
    // ---------------------------------------------------------------
    always_comb begin
        ld_grant = 1'b0;
        f_grant  = 1'b0;

        // Grants are suppressed while reset is held so nothing reaches memory.
        if (reset) begin
            if (state_reg == ST_BOOT) begin
                ld_grant = bus.ld_valid;
            end else if (bus.ld_valid && bus.f_valid) begin
                if (wait_reg == WAIT_MAX) begin
                    f_grant = 1'b1;
                end else begin
                    ld_grant = 1'b1;
                end
            end else begin
                ld_grant = bus.ld_valid;
                f_grant  = bus.f_valid;
            end
        end

        // Out-of-range writes are acknowledged but never reach the memory.
        ld_issue = ld_grant & ld_in_range;

        bus.ld_ready  = ld_grant;
        bus.f_ready   = f_grant;

        // Idle default is a read of address 0: never an accidental write.
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        if (ld_issue) begin
            bus.mem_rw    = 1'b0;
            bus.mem_addr  = bus.ld_addr;
            bus.mem_wdata = bus.ld_data;
        end else if (f_grant) begin
            bus.mem_addr  = bus.f_addr;
        end

        // mem_rdata belongs to the read issued last cycle; a write issued this
        // cycle only changes what the memory returns next cycle.
        bus.f_rvalid = rvalid_reg;
        bus.f_rdata  = rvalid_reg ? bus.mem_rdata : 32'd0;

        bus.running  = (state_reg == ST_RUN);
        bus.err      = err_reg;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed scenarios followed by randomized
// traffic, all checked each cycle against a transaction-level model.
module tb_imem_arbiter;

    localparam int AB    = 5;
    localparam int MW    = 4;
    localparam int DEPTH = 1 << AB;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    imem_arbiter_if bus ();

    imem_arbiter #(
        .ADDR_BITS (AB),
        .MAX_WAIT  (MW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------
    // Memory attached to the arbiter: synchronous, registered read.
    // ---------------------------------------------------------------
    logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};

    always @(posedge clk) begin
        if (bus.mem_rw == 1'b0) mem[bus.mem_addr[AB-1:0]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[AB-1:0]];
    end

    // ---------------------------------------------------------------
    // Reference model: booted flag, count of lost fetch contentions,
    // sticky error, expected memory image and one pending read.
    // ---------------------------------------------------------------
    bit          m_run  = 1'b0;
    bit          m_err  = 1'b0;
    bit          m_pend = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_pdata = 32'h0;
    logic [31:0] ref_img [0:DEPTH-1] = '{default: 32'h0};
    bit          ld_xfer = 1'b0;

    always @(negedge clk) begin : model
        bit lg;
        bit fg;
        bit wr;
        if (!reset) begin
            m_run  = 1'b0;
            m_err  = 1'b0;
            m_pend = 1'b0;
            m_wait = 0;
            ld_xfer = 1'b0;
            chk("rst_ld_ready",  bus.ld_ready,  32'd0);
            chk("rst_f_ready",   bus.f_ready,   32'd0);
            chk("rst_f_rvalid",  bus.f_rvalid,  32'd0);
            chk("rst_f_rdata",   bus.f_rdata,   32'd0);
            chk("rst_mem_rw",    bus.mem_rw,    32'd1);
            chk("rst_mem_addr",  bus.mem_addr,  32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
            chk("rst_running",   bus.running,   32'd0);
            chk("rst_err",       bus.err,       32'd0);
        end else begin
            lg = 1'b0;
            fg = 1'b0;
            if (!m_run) begin
                lg = bus.ld_valid;
            end else if (bus.ld_valid && bus.f_valid) begin
                if (m_wait >= MW) fg = 1'b1;
                else              lg = 1'b1;
            end else begin
                lg = bus.ld_valid;
                fg = bus.f_valid;
            end
            wr = lg && (bus.ld_addr < DEPTH);

            chk("ld_ready", bus.ld_ready, lg);
            chk("f_ready",  bus.f_ready,  fg);
            if (wr) begin
                chk("mem_rw_wr",    bus.mem_rw,    32'd0);
                chk("mem_addr_wr",  bus.mem_addr,  bus.ld_addr);
                chk("mem_wdata_wr", bus.mem_wdata, bus.ld_data);
            end else if (fg) begin
                chk("mem_rw_rd",    bus.mem_rw,    32'd1);
                chk("mem_addr_rd",  bus.mem_addr,  bus.f_addr);
            end else begin
                chk("mem_rw_idle",    bus.mem_rw,    32'd1);
                chk("mem_addr_idle",  bus.mem_addr,  32'd0);
                chk("mem_wdata_idle", bus.mem_wdata, 32'd0);
            end
            chk("f_rvalid", bus.f_rvalid, m_pend);
            chk("f_rdata",  bus.f_rdata,  m_pend ? m_pdata : 32'd0);
            chk("running",  bus.running,  m_run);
            chk("err",      bus.err,      m_err);

            ld_xfer = bus.ld_valid && bus.ld_ready;

            // advance to the state after the coming rising edge
            m_pend = fg;
            if (fg) m_pdata = ref_img[bus.f_addr[AB-1:0]];
            if (wr) ref_img[bus.ld_addr[AB-1:0]] = bus.ld_data;
            if (lg && !wr) m_err = 1'b1;
            if (m_run) begin
                if (fg)                          m_wait = 0;
                else if (bus.f_valid && m_wait < MW) m_wait = m_wait + 1;
            end else if (bus.boot_done && !bus.ld_valid) begin
                m_run = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] boot_img [0:3] = '{32'h13, 32'h93, 32'h113, 32'h193};

    initial begin
        int  k;
        bit  got;

        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'd0;
        bus.ld_data   = 32'h0;
        bus.boot_done = 1'b0;
        bus.f_valid   = 1'b1;
        bus.f_addr    = 32'd0;
        reset         = 1'b0;

        // held in reset with both requesters active
        mid();
        chk("reset_running", bus.running, 32'd0);
        chk("reset_no_write", bus.mem_rw, 32'd1);
        tick();

        // boot load: first write granted on the first edge after release
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = i;
            bus.ld_data  = boot_img[i];
            mid();
            chk("boot_f_ready",   bus.f_ready,   32'd0);
            chk("boot_ld_ready",  bus.ld_ready,  32'd1);
            chk("boot_mem_rw",    bus.mem_rw,    32'd0);
            chk("boot_mem_wdata", bus.mem_wdata, boot_img[i]);
            tick();
        end
        bus.ld_valid  = 1'b0;
        bus.boot_done = 1'b1;
        mid();
        chk("boot_done_running", bus.running, 32'd0);
        tick();
        bus.boot_done = 1'b0;

        // back-to-back fetch stream
        for (int i = 0; i < 5; i++) begin
            bus.f_valid = (i < 4);
            bus.f_addr  = i;
            mid();
            if (i == 0) chk("run_entered", bus.running, 32'd1);
            if (i < 4)  chk("stream_f_ready", bus.f_ready, 32'd1);
            if (i > 0) begin
                chk("stream_rvalid", bus.f_rvalid, 32'd1);
                chk("stream_rdata",  bus.f_rdata,  boot_img[i-1]);
            end
            tick();
        end

        // starvation: both held valid, fetch wins every fifth cycle
        k = 0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'd8;
        bus.ld_data  = 32'h100;
        bus.f_valid  = 1'b1;
        bus.f_addr   = 32'd2;
        for (int c = 0; c < 10; c++) begin
            mid();
            chk("starve_f_ready",  bus.f_ready,  (c % 5 == 4) ? 32'd1 : 32'd0);
            chk("starve_ld_ready", bus.ld_ready, (c % 5 == 4) ? 32'd0 : 32'd1);
            got = bus.ld_ready;
            tick();
            if (got) begin
                k++;
                bus.ld_addr = 32'd8 + k;
                bus.ld_data = 32'h100 + k;
            end
        end
        bus.ld_valid = 1'b0;
        bus.f_valid  = 1'b0;

        // out-of-range write
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'd32;
        bus.ld_data  = 32'hdead;
        mid();
        chk("range_ld_ready", bus.ld_ready, 32'd1);
        chk("range_mem_rw",   bus.mem_rw,   32'd1);
        tick();
        bus.ld_valid = 1'b0;
        repeat (3) begin
            mid();
            chk("range_err_sticky", bus.err, 32'd1);
            tick();
        end

        // reset during an outstanding read
        bus.f_valid = 1'b1;
        bus.f_addr  = 32'd1;
        mid();
        chk("rmr_f_ready", bus.f_ready, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rmr_f_rvalid", bus.f_rvalid, 32'd0);
        chk("rmr_running",  bus.running,  32'd0);
        chk("rmr_mem_rw",   bus.mem_rw,   32'd1);
        chk("rmr_err",      bus.err,      32'd0);
        tick();
        chk("rmr_f_rvalid_after_edge", bus.f_rvalid, 32'd0);
        bus.f_valid = 1'b0;
        tick();

        // deferred boot exit
        reset         = 1'b1;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'd20;
        bus.ld_data   = 32'h55;
        bus.boot_done = 1'b1;
        mid();
        chk("defer_ld_ready", bus.ld_ready, 32'd1);
        chk("defer_running0", bus.running,  32'd0);
        tick();
        bus.ld_valid = 1'b0;
        mid();
        chk("defer_running1", bus.running, 32'd0);
        tick();
        bus.boot_done = 1'b0;
        mid();
        chk("defer_running2", bus.running, 32'd1);
        tick();

        // randomized traffic with occasional resets
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (!(bus.ld_valid && !ld_xfer)) begin
                bus.ld_valid = $urandom_range(0, 1);
                bus.ld_addr  = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, DEPTH - 1);
                bus.ld_data  = $urandom;
            end
            if (!(bus.f_valid && !bus.f_ready)) begin
                bus.f_valid = ($urandom_range(0, 9) < 6);
                bus.f_addr  = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, DEPTH - 1);
            end
            bus.boot_done = ($urandom_range(0, 9) == 0);
            tick();
        end

        mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 5: number of word-address bits the instruction memory decodes (32 words).
REQ-002 Parameter MAX_WAIT, default 4: number of consecutive lost fetch arbitrations after which fetch is forced to win.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of clk.
REQ-005 ld_valid  input  1  loader write request.
REQ-006 ld_addr  input  32  loader word address.
REQ-007 ld_data  input  32  loader write data.
REQ-008 ld_ready  output  1  loader request accepted this cycle.
REQ-009 boot_done  input  1  loader signals that the program image is complete.
REQ-010 f_valid  input  1  fetch read request.
REQ-011 f_addr  input  32  fetch word address.
REQ-012 f_ready  output  1  fetch request accepted this cycle.
REQ-013 f_rdata  output  32  fetch read data, valid only while f_rvalid=1.
REQ-014 f_rvalid  output  1  read data for the fetch accepted in the previous cycle.
REQ-015 mem_addr  output  32  memory address; mem_wdata  output  32  memory write data; mem_rw  output  1  0=write, 1=read; mem_rdata  input  32  registered memory read data (one-cycle latency).
REQ-016 running  output  1  1 in RUN state; err  output  1  sticky out-of-range write flag.

Function
REQ-017 The block SHALL implement two states: BOOT (entered on reset) and RUN.
REQ-018 In BOOT, f_ready SHALL be 0; ld_ready SHALL equal ld_valid.
REQ-019 BOOT->RUN SHALL occur on the rising edge on which boot_done=1 and ld_valid=0; if ld_valid=1 that cycle, the write completes and the transition is deferred to the first edge with ld_valid=0 and boot_done=1.
REQ-020 RUN SHALL persist until reset; boot_done is ignored in RUN.
REQ-021 In RUN, at most one request SHALL be granted per cycle; the loader wins by default when both are valid.
REQ-022 A wait counter SHALL increment on each RUN cycle with f_valid=1 and f_ready=0, saturating at MAX_WAIT, and SHALL clear on every fetch grant.
REQ-023 When the wait counter equals MAX_WAIT, fetch SHALL win the next contention; the loader is stalled (ld_ready=0) for that cycle.
REQ-024 Handshakes: a request is transferred on an edge where valid and ready are both 1; requesters hold address/data stable while valid=1 and ready=0.
REQ-025 Memory drive SHALL be combinational from the granted request: loader grant -> mem_rw=0, mem_addr=ld_addr, mem_wdata=ld_data; fetch grant -> mem_rw=1, mem_addr=f_addr.
REQ-026 With no grant, mem_rw SHALL be 1 (never an unintended write), mem_addr and mem_wdata 0.
REQ-027 f_rvalid SHALL be 1 exactly in the cycle after a fetch grant, with f_rdata=mem_rdata; otherwise f_rdata=0.
REQ-028 Back-to-back fetch grants SHALL be allowed, giving one f_rvalid per cycle.
REQ-029 A write granted in the cycle after a fetch grant SHALL NOT corrupt that cycle's f_rdata.
REQ-030 A loader write with ld_addr >= 2^ADDR_BITS SHALL be handshaked (ld_ready=1) but not issued (mem_rw stays 1) and SHALL set err; err clears only on reset.
REQ-031 Fetch addresses are not range-checked; mem_addr passes f_addr unmodified.

Reset
REQ-032 While reset=0: state=BOOT, wait counter=0, err=0, running=0, ld_ready=0, f_ready=0, f_rvalid=0, f_rdata=0, mem_rw=1, mem_addr=0, mem_wdata=0.
REQ-033 Reset asserted mid-operation SHALL discard any pending f_rvalid; no memory write SHALL be issued while reset=0.
REQ-034 After reset release, the first grant SHALL occur on the first rising edge with reset=1.

Verification
REQ-035 Boot load: writes addr 0..3 data 0x13,0x93,0x113,0x193, f_valid=1 throughout -> f_ready=0 in BOOT, four mem_rw=0 cycles, then boot_done=1 -> running=1 next edge.
REQ-036 Fetch stream: RUN, f_addr 0,1,2,3 back-to-back -> f_rvalid=1 for four consecutive cycles, f_rdata 0x13,0x93,0x113,0x193.
REQ-037 Starvation: RUN, ld_valid and f_valid held 1, MAX_WAIT=4 -> four loader grants, then one fetch grant, counter 0, pattern repeats.
REQ-038 Range error: ld_addr=32, ADDR_BITS=5 -> ld_ready=1, mem_rw stays 1, err=1 until reset.
REQ-039 Reset mid-read: fetch grant, reset=0 before next edge -> f_rvalid=0, state BOOT, running=0, mem_rw=1.
REQ-040 Deferred boot exit: boot_done=1 with ld_valid=1 -> write completes, running=1 only after the edge with ld_valid=0.
